mux6_rr_arbiter: RTL and testbench

//  - Round-robin arbiter sharing one 6-way one-hot 3-bit mux (driven via OR6) among six requesters.
//  - Produces the registered one-hot select (grant) for that mux plus an encoded owner index.
//  - Break-before-make: at least one all-zero grant cycle separates owners.
//    Two select bits high at once would OR two data words together.
//  - Sits between requesting units and the shared mux in the datapath.

---
 rtl/mux6_rr_arbiter_if.sv | 26 ++
 rtl/mux6_rr_arbiter.sv | 150 +++++++++++++++
 tb/tb_mux6_rr_arbiter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/mux6_rr_arbiter_if.sv
// Interface bundling the request/select signals between six requesters and the
// arbiter that drives the shared 6-way one-hot mux select.
// The arbiter side uses the master modport; the requester side uses slave.
interface mux6_rr_arbiter_if;
    logic [5:0] req;
    logic [5:0] grant;
    logic [2:0] owner;
    logic       busy;
    logic       preempt;

    modport master (
        input  req,
        output grant,
        output owner,
        output busy,
        output preempt
    );

    modport slave (
        output req,
        input  grant,
        input  owner,
        input  busy,
        input  preempt
    );
endinterface

// File: rtl/mux6_rr_arbiter.sv
// Round-robin arbiter for one shared 6-way one-hot mux.
// grant is the registered one-hot mux select; it always drops to zero for at
// least one cycle between owners, so two data words are never ORed together.
// Optional feature: define ARB_HOLD_LIMIT_EN to force-release an owner after
// MAX_HOLD consecutive grant cycles (preempt pulses in the following zero cycle).
module mux6_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 8
) (
    input logic                clk,
    input logic                rst,
    mux6_rr_arbiter_if.master  arb
);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StGrant   = 2'd1,
        StRelease = 2'd2
    } state_e;

    if (MAX_HOLD < 2 || MAX_HOLD > 15) begin : gen_bad_max_hold
        $error("mux6_rr_arbiter: MAX_HOLD must be in 2..15");
    end

    state_e     state_q, state_d;
    logic [5:0] grant_q, grant_d;
    logic [2:0] owner_q, owner_d;
    logic [2:0] ptr_q, ptr_d;

`ifdef ARB_HOLD_LIMIT_EN
    localparam int unsigned HoldW = 4;
    localparam logic [HoldW-1:0] HoldLast = HoldW'(MAX_HOLD - 1);

    logic [HoldW-1:0] hold_q, hold_d;
    logic             preempt_q, preempt_d;
`endif

    logic       pick_hit;
    logic [2:0] pick_idx;
    logic [2:0] ptr_after_owner;

    // First requester at or after ptr, wrapping 5 -> 0. Scanning backwards lets
    // the highest-priority hit be the last one written, so no early exit needed.
    function automatic logic [3:0] arb_pick(input logic [5:0] r, input logic [2:0] p);
        logic [3:0] res;
        int         base;
        int         idx;
        logic [2:0] idx3;
        res  = '0;
        base = (p > 3'd5) ? 0 : int'(p);
        for (int k = 5; k >= 0; k--) begin
            idx  = (base + k) % 6;
            idx3 = 3'(idx);
            if (r[idx3]) begin
                res = {1'b1, idx3};
            end
        end
        return res;
    endfunction

    // Arbitration result and the pointer value used after the current owner leaves.
    always_comb begin
        {pick_hit, pick_idx} = arb_pick(arb.req, ptr_q);
        ptr_after_owner      = (owner_q == 3'd5) ? 3'd0 : owner_q + 3'd1;
    end

    // State and datapath registers; reset clears the select immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            grant_q   <= '0;
            owner_q   <= '0;
            ptr_q     <= '0;
`ifdef ARB_HOLD_LIMIT_EN
            hold_q    <= '0;
            preempt_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
`ifdef ARB_HOLD_LIMIT_EN
            hold_q    <= hold_d;
            preempt_q <= preempt_d;
`endif
        end
    end

    // Next-state logic: arbitrate from idle/release, hold or release in grant.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
`ifdef ARB_HOLD_LIMIT_EN
        hold_d    = hold_q;
        preempt_d = 1'b0;
`endif
        case (state_q)
            StIdle, StRelease: begin
                if (pick_hit) begin
                    grant_d = 6'b000001 << pick_idx;
                    owner_d = pick_idx;
                    state_d = StGrant;
`ifdef ARB_HOLD_LIMIT_EN
                    hold_d  = '0;
`endif
                end else begin
                    grant_d = '0;
                    state_d = StIdle;
                end
            end
            StGrant: begin
                if (!arb.req[owner_q]) begin
                    grant_d = '0;
                    ptr_d   = ptr_after_owner;
                    state_d = StRelease;
`ifdef ARB_HOLD_LIMIT_EN
                end else if (hold_q == HoldLast) begin
                    // Owner used its full budget: force a release, owner re-competes last.
                    grant_d   = '0;
                    ptr_d     = ptr_after_owner;
                    state_d   = StRelease;
                    preempt_d = 1'b1;
                end else if (hold_q != '1) begin
                    hold_d = hold_q + 1'b1;
`endif
                end
            end
            default: begin
                // Unreachable encoding: drop the select and start over.
                grant_d = '0;
                state_d = StIdle;
            end
        endcase
    end

    // Outputs straight from registers so the mux select is glitch-free.
    always_comb begin
        arb.grant   = grant_q;
        arb.owner   = owner_q;
        arb.busy    = |grant_q;
`ifdef ARB_HOLD_LIMIT_EN
        arb.preempt = preempt_q;
`else
        arb.preempt = 1'b0;
`endif
    end

endmodule

// File: tb/tb_mux6_rr_arbiter.sv
// Directed self-checking bench for mux6_rr_arbiter (hold-limit case follows the
// ARB_HOLD_LIMIT_EN build with MAX_HOLD=4).
module tb_mux6_rr_arbiter;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    mux6_rr_arbiter_if arb_if ();

    mux6_rr_arbiter #(
        .MAX_HOLD (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .arb (arb_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #20000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [5:0] g, input logic [2:0] o,
                              input logic p);
        check({tag, ".grant"}, {2'b0, arb_if.grant}, {2'b0, g});
        check({tag, ".owner"}, {5'b0, arb_if.owner}, {5'b0, o});
        check({tag, ".busy"}, {7'b0, arb_if.busy}, {7'b0, |g});
        check({tag, ".preempt"}, {7'b0, arb_if.preempt}, {7'b0, p});
    endtask

    initial begin
        logic [5:0] onehot;
        checks   = 0;
        failures = 0;

        // T1: reset with all requests high.
        rst        = 1'b1;
        arb_if.req = 6'h3F;
        step();
        expect_out("t1_rst", 6'b000000, 3'd0, 1'b0);
        rst = 1'b0;
        step();
        expect_out("t1_first", 6'b000001, 3'd0, 1'b0);

        // T3: rotation, each owner drops for one cycle then re-raises.
        for (int i = 0; i < 6; i++) begin
            arb_if.req[i] = 1'b0;
            step();
            expect_out($sformatf("t3_gap%0d", i), 6'b000000, 3'(i), 1'b0);
            arb_if.req[i] = 1'b1;
            step();
            onehot = 6'b000001 << ((i + 1) % 6);
            expect_out($sformatf("t3_own%0d", (i + 1) % 6), onehot, 3'((i + 1) % 6), 1'b0);
        end

        // T4: wrap; get owner 5, release it so ptr=0, then 0 wins over 4.
        arb_if.req = 6'b100000;
        step();
        expect_out("t4_gap0", 6'b000000, 3'd0, 1'b0);
        step();
        expect_out("t4_own5", 6'b100000, 3'd5, 1'b0);
        arb_if.req = 6'b010001;
        step();
        expect_out("t4_gap5", 6'b000000, 3'd5, 1'b0);
        step();
        expect_out("t4_own0", 6'b000001, 3'd0, 1'b0);
        arb_if.req = 6'b010000;
        step();
        step();
        expect_out("t4_own4", 6'b010000, 3'd4, 1'b0);
        arb_if.req = 6'b000000;
        step();
        step();
        step();
        expect_out("t4_idle", 6'b000000, 3'd4, 1'b0);

        // T2: single requester, one-cycle latency, then stays idle.
        arb_if.req = 6'b001000;
        step();
        expect_out("t2_own3", 6'b001000, 3'd3, 1'b0);
        arb_if.req = 6'b000000;
        step();
        expect_out("t2_rel", 6'b000000, 3'd3, 1'b0);
        step();
        step();
        expect_out("t2_idle", 6'b000000, 3'd3, 1'b0);

        // T5: owner 2 with requester 1 also waiting (ptr=4 now).
        arb_if.req = 6'b000100;
        step();
        expect_out("t5_own2", 6'b000100, 3'd2, 1'b0);
        arb_if.req = 6'b000110;
`ifdef ARB_HOLD_LIMIT_EN
        for (int c = 1; c < 4; c++) begin
            step();
            expect_out($sformatf("t5_hold%0d", c), 6'b000100, 3'd2, 1'b0);
        end
        step();
        expect_out("t5_preempt", 6'b000000, 3'd2, 1'b1);
        step();
        expect_out("t5_own1", 6'b000010, 3'd1, 1'b0);
        // Hand the mux back to 2 for the async reset test.
        arb_if.req = 6'b000100;
        step();
        step();
        expect_out("t6_pre", 6'b000100, 3'd2, 1'b0);
`else
        for (int c = 1; c <= 50; c++) begin
            step();
            check($sformatf("t5_hold%0d", c), {2'b0, arb_if.grant}, 8'h04);
            check($sformatf("t5_nopre%0d", c), {7'b0, arb_if.preempt}, 8'h00);
        end
        arb_if.req = 6'b000100;
        step();
        expect_out("t6_pre", 6'b000100, 3'd2, 1'b0);
`endif

        // T6: async reset mid-cycle clears outputs before any clock edge.
        #2;
        rst = 1'b1;
        #1;
        expect_out("t6_async", 6'b000000, 3'd0, 1'b0);
        step();
        rst        = 1'b0;
        arb_if.req = 6'b000110;
        step();
        expect_out("t6_after", 6'b000010, 3'd1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
